usb_rx_stream: RTL and testbench

Parametrised USB full-speed packet receiver. It replaces the fixed 8-clocks-per-bit, fixed-FIFO receiver path with one that has configurable oversampling and FIFO depth. It adds bit-unstuffing, SYNC pattern checking, packet-boundary reporting and a FIFO fill count. It sits between the D+/D- pads and the downstream packet decoder, which drains bytes through a read-enable FIFO port.

---
 rtl/usb_rx_stream.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_usb_rx_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_stream.sv
// USB full-speed receive path: pad synchronisers, NRZI/bit-unstuff decoder, framing FSM, byte FIFO.
// Optional CRC16 residual check at EOP is compiled in with USB_RX_CRC16_EN.

// Generic byte FIFO with show-ahead head and zeroed read data while empty.
// Latency: write visible at rd_dat one clock after push; count updates on the same edge.
// Backpressure: wr_rdy low when full unless a pop frees the slot in the same cycle.
module usb_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [W-1:0]           rd_dat,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign rd_vld = (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop    = rd_vld & rd_rdy;
  assign wr_rdy = ~full | pop;
  assign push   = wr_vld & wr_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// USB full-speed packet receiver: recovers bits, checks SYNC, unstuffs, assembles bytes into FIFO.
// Latency: last data bit sample to byte at r_data is 2 clocks when the FIFO was empty.
// Backpressure: none toward the line; a byte arriving at a full FIFO is dropped and flags r_error.
module usb_rx_stream #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_plus,
  input  logic             d_minus,
  input  logic             r_enable,
  output logic [7:0]       r_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             rcving,
  output logic             pkt_done,
  output logic             r_error
);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_MID = TMR_W'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_WAIT, ERR_WAIT} state_t;

  state_t           state_q, state_d;
  logic             dp_s1, dp_s2, dp_q, dm_s1, dm_s2;
  logic [TMR_W-1:0] bit_tmr;
  logic             prev_lvl;
  logic [6:0]       shift_q;
  logic [7:0]       shift_nxt;
  logic [2:0]       bit_cnt;
  logic [2:0]       ones_cnt;
  logic             se0_seen;
  logic             wr_vld, wr_rdy, rd_vld;
  logic [7:0]       wr_dat;
  logic             wr_drop;
  logic             crc_ok;

  logic dp_edge, dp_fall, samp, se0, line_j, nrzi_bit;
  logic start, take_bit, stuff_drop, sync_ok, byte_end, err_set, done_set;

  // J idles with D+ high, so D+ resets high and D- low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1 <= 1'b1;
      dp_s2 <= 1'b1;
      dp_q  <= 1'b1;
      dm_s1 <= 1'b0;
      dm_s2 <= 1'b0;
    end else begin
      dp_s1 <= d_plus;
      dp_s2 <= dp_s1;
      dp_q  <= dp_s2;
      dm_s1 <= d_minus;
      dm_s2 <= dm_s1;
    end
  end

  assign dp_edge   = dp_s2 ^ dp_q;
  assign dp_fall   = dp_q & ~dp_s2;
  assign samp      = (bit_tmr == TMR_MID);
  assign se0       = ~dp_s2 & ~dm_s2;
  assign line_j    = dp_s2 & ~dm_s2;
  assign nrzi_bit  = (dp_s2 == prev_lvl);
  assign shift_nxt = {nrzi_bit, shift_q};

  // Every D+ transition re-centres the sample point on the current bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     bit_tmr <= '0;
    else if (dp_edge)            bit_tmr <= '0;
    else if (bit_tmr == TMR_MAX) bit_tmr <= '0;
    else                         bit_tmr <= bit_tmr + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    take_bit   = 1'b0;
    stuff_drop = 1'b0;
    sync_ok    = 1'b0;
    byte_end   = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dp_fall) begin
          start   = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (samp) begin
          take_bit = 1'b1;
          if (bit_cnt == 3'd7) begin
            if (shift_nxt == 8'h80) begin
              sync_ok = 1'b1;
              state_d = DATA;
            end else begin
              err_set = 1'b1;
              state_d = ERR_WAIT;
            end
          end
        end
      end
      DATA: begin
        if (samp) begin
          if (se0) begin
            if (bit_cnt == 3'd0) begin
              state_d = EOP_WAIT;
            end else begin
              err_set = 1'b1;
              state_d = ERR_WAIT;
            end
          end else if (ones_cnt == 3'd6) begin
            // Seventh bit after six ones must be a stuffed zero
            if (nrzi_bit) begin
              err_set = 1'b1;
              state_d = ERR_WAIT;
            end else begin
              stuff_drop = 1'b1;
            end
          end else begin
            take_bit = 1'b1;
            byte_end = (bit_cnt == 3'd7);
          end
        end
      end
      EOP_WAIT: begin
        if (samp && line_j) begin
          state_d = IDLE;
          if (!crc_ok) err_set  = 1'b1;
          else         done_set = ~r_error;
        end
      end
      ERR_WAIT: begin
        if (samp && line_j && se0_seen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_lvl <= 1'b1;
      shift_q  <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      se0_seen <= 1'b0;
      wr_vld   <= 1'b0;
      wr_dat   <= '0;
      r_error  <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= done_set;
      wr_vld   <= byte_end;
      if (byte_end) wr_dat <= shift_nxt;
      if (start) begin
        prev_lvl <= 1'b1;
        bit_cnt  <= '0;
        ones_cnt <= '0;
        se0_seen <= 1'b0;
        r_error  <= 1'b0;
      end else begin
        if (samp && (state_q == SYNC || state_q == DATA)) prev_lvl <= dp_s2;
        if (take_bit) begin
          shift_q <= shift_nxt[7:1];
          bit_cnt <= bit_cnt + 3'd1;
        end
        // The final SYNC bit is a one and opens the first stuffing run
        if (sync_ok)         ones_cnt <= 3'd1;
        else if (stuff_drop) ones_cnt <= '0;
        else if (take_bit)   ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
        if (samp && se0 && (state_q == DATA || state_q == ERR_WAIT)) se0_seen <= 1'b1;
        if (err_set || wr_drop) r_error <= 1'b1;
      end
    end
  end

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc_q;
  logic [15:0] crc_nxt;

  // Reflected 0x8005; running over the received CRC bytes leaves residual 0xB001
  assign crc_nxt = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ nrzi_bit) ? 16'hA001 : 16'h0000);
  assign crc_ok  = (crc_q == 16'hB001);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              crc_q <= 16'hFFFF;
    else if (start)                       crc_q <= 16'hFFFF;
    else if (take_bit && state_q == DATA) crc_q <= crc_nxt;
  end
`else
  assign crc_ok = 1'b1;
`endif

  assign wr_drop = wr_vld & ~wr_rdy;
  assign empty   = ~rd_vld;
  assign rcving  = (state_q != IDLE);

  usb_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (wr_vld),
    .wr_dat (wr_dat),
    .wr_rdy (wr_rdy),
    .rd_vld (rd_vld),
    .rd_rdy (r_enable),
    .rd_dat (r_data),
    .full   (full),
    .count  (count)
  );
endmodule

// File: tb/tb_usb_rx_stream.sv
// Directed bench for usb_rx_stream: NRZI/stuffing line driver, FIFO drain and flag checks.
module tb_usb_rx_stream;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             d_plus;
  logic             d_minus;
  logic             r_enable;
  logic [7:0]       r_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             rcving;
  logic             pkt_done;
  logic             r_error;

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic lvl;
  int   ones;

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

  usb_rx_stream #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .r_enable (r_enable),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .rcving   (rcving),
    .pkt_done (pkt_done),
    .r_error  (r_error)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_bit(input logic b);
    if (!b) lvl = ~lvl;
    d_plus  = lvl;
    d_minus = ~lvl;
    tick(CPB);
  endtask

  task automatic tx_byte(input logic [7:0] v, input logic stuff);
    for (int i = 0; i < 8; i++) begin
      tx_bit(v[i]);
      ones = v[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        tx_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic tx_sync();
    lvl  = 1'b1;
    ones = 0;
    tx_byte(8'h80, 1'b1);
  endtask

  task automatic tx_eop();
    d_plus  = 1'b0;
    d_minus = 1'b0;
    tick(2 * CPB);
    lvl     = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    tick(CPB + 4);
  endtask

  task automatic pop();
    r_enable = 1'b1;
    tick(1);
    r_enable = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    d_plus   = 1'b1;
    d_minus  = 1'b0;
    r_enable = 1'b0;
    lvl      = 1'b1;
    ones     = 0;
    tick(2);
    @(negedge clk);
    check("rst_r_data", r_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_rcving", rcving, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_r_error", r_error, 0);
    rst = 1'b0;
    tick(4);

    // Clean two-byte packet
    tx_sync();
    check("t1_rcving_mid", rcving, 1);
    check("t1_err_mid", r_error, 0);
    tx_byte(8'hA5, 1'b1);
    tx_byte(8'h3C, 1'b1);
    tx_eop();
    @(negedge clk);
    check("t1_count", count, 2);
    check("t1_head", r_data, 8'hA5);
    check("t1_r_error", r_error, 0);
    check("t1_rcving", rcving, 0);
    check("t1_done", done_cnt, 1);
    pop();
    @(negedge clk);
    check("t1_second", r_data, 8'h3C);
    check("t1_count1", count, 1);
    pop();
    @(negedge clk);
    check("t1_empty", empty, 1);
    check("t1_data_empty", r_data, 0);

    // All-ones payload with stuffed zeros
    tx_sync();
    tx_byte(8'hFF, 1'b1);
    tx_byte(8'hFF, 1'b1);
    tx_eop();
    @(negedge clk);
    check("t2_count", count, 2);
    check("t2_head", r_data, 8'hFF);
    check("t2_r_error", r_error, 0);
    check("t2_done", done_cnt, 2);
    pop();
    @(negedge clk);
    check("t2_second", r_data, 8'hFF);
    pop();
    @(negedge clk);
    check("t2_empty", empty, 1);

    // Missing stuff bit: seventh consecutive one
    tx_sync();
    tx_byte(8'hFF, 1'b0);
    tx_byte(8'hFF, 1'b0);
    tx_eop();
    @(negedge clk);
    check("t2b_r_error", r_error, 1);
    check("t2b_done", done_cnt, 2);
    check("t2b_count", count, 0);
    check("t2b_rcving", rcving, 0);

    // Bad SYNC decoding to 8'h81: short K glitch then a J bit gives a leading one
    d_plus  = 1'b0;
    d_minus = 1'b1;
    tick(2);
    lvl     = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    tick(CPB);
    for (int i = 0; i < 6; i++) tx_bit(1'b0);
    tx_bit(1'b1);
    check("t3_rcving_mid", rcving, 1);
    check("t3_err_mid", r_error, 1);
    tx_eop();
    @(negedge clk);
    check("t3_r_error", r_error, 1);
    check("t3_empty", empty, 1);
    check("t3_rcving", rcving, 0);
    check("t3_done", done_cnt, 2);

    // Overflow: six bytes into a four-entry FIFO
    tx_sync();
    tx_byte(8'h11, 1'b1);
    tx_byte(8'h22, 1'b1);
    tx_byte(8'h33, 1'b1);
    tx_byte(8'h44, 1'b1);
    tx_byte(8'h55, 1'b1);
    tx_byte(8'h66, 1'b1);
    tx_eop();
    @(negedge clk);
    check("t4_full", full, 1);
    check("t4_count", count, 4);
    check("t4_r_error", r_error, 1);
    check("t4_done", done_cnt, 2);
    check("t4_rcving", rcving, 0);
    check("t4_b0", r_data, 8'h11);
    pop();
    @(negedge clk);
    check("t4_b1", r_data, 8'h22);
    check("t4_not_full", full, 0);
    pop();
    @(negedge clk);
    check("t4_b2", r_data, 8'h33);
    pop();
    @(negedge clk);
    check("t4_b3", r_data, 8'h44);
    pop();
    @(negedge clk);
    check("t4_empty", empty, 1);
    pop();
    @(negedge clk);
    check("t4_pop_empty_count", count, 0);

    // EOP after three data bits, then a clean packet
    tx_sync();
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_eop();
    @(negedge clk);
    check("t5_r_error", r_error, 1);
    check("t5_empty", empty, 1);
    check("t5_done", done_cnt, 2);
    check("t5_rcving", rcving, 0);
    tx_sync();
    check("t5_err_cleared", r_error, 0);
    tx_byte(8'h5A, 1'b1);
    tx_eop();
    @(negedge clk);
    check("t5_clean_err", r_error, 0);
    check("t5_clean_done", done_cnt, 3);
    check("t5_clean_count", count, 1);
    check("t5_clean_data", r_data, 8'h5A);

    // Reset mid-byte with a byte still queued
    tx_sync();
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b1);
    tx_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_r_data", r_data, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_count", count, 0);
    check("t6_rcving", rcving, 0);
    check("t6_pkt_done", pkt_done, 0);
    check("t6_r_error", r_error, 0);
    lvl     = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);
    tx_sync();
    tx_byte(8'hA5, 1'b1);
    tx_eop();
    @(negedge clk);
    check("t6_post_count", count, 1);
    check("t6_post_data", r_data, 8'hA5);
    check("t6_post_err", r_error, 0);
    check("t6_post_done", done_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
